// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one registered integer ALU between NREQ
// requesters; one op in flight, result returned over a valid/ready channel.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  per-requester request handshake (ready is one-hot or 0)
//   req_op/in1/in2       packed per-requester payloads (15/32/32 bits each)
//   alu_*                registered operand and op-select drive to the ALU
//   alu_out              registered ALU result
//   rsp_*                response channel: valid/ready, owner id, data, error
//   busy                 FSM not idle
module alu_arbiter #(
  parameter int NREQ    = 2,
  parameter int IDW     = 1,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*15-1:0] req_op,
  input  logic [NREQ*32-1:0] req_in1,
  input  logic [NREQ*32-1:0] req_in2,
  output logic [6:0]        alu_funct7,
  output logic [2:0]        alu_funct3,
  output logic [4:0]        alu_opcode,
  output logic [31:0]       alu_in1,
  output logic [31:0]       alu_in2,
  input  logic [31:0]       alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [6:0]      f7_q, f7_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      opc_q, opc_d;
  logic [31:0]     in1_q, in1_d;
  logic [31:0]     in2_q, in2_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [31:0]     data_q, data_d;
  logic            err_q, err_d;

  logic [14:0]     op_a  [NREQ];
  logic [31:0]     in1_a [NREQ];
  logic [31:0]     in2_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_a[g]  = req_op[15*g +: 15];
    assign in1_a[g] = req_in1[32*g +: 32];
    assign in2_a[g] = req_in2[32*g +: 32];
  end

  // Rotating-priority scan starting at ptr; idx stays below 2*NREQ so
  // one conditional subtract performs the wrap.
  logic            found;
  logic [PW-1:0]   win;
  logic [PW:0]     idx;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!found && req_valid[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  logic op_ok;

  always_comb begin
    op_ok = 1'b0;
    if (opc_q == 5'b01100) begin
      unique case (1'b1)
        (f7_q == 7'h00): op_ok = 1'b1;
        (f7_q == 7'h20): op_ok = (f3_q == 3'd0) || (f3_q == 3'd5);
        default:         op_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    f7_d      = f7_q;
    f3_d      = f3_q;
    opc_d     = opc_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    id_d      = id_q;
    data_d    = data_q;
    err_d     = err_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[win] = 1'b1;
          {f7_d, f3_d, opc_d} = op_a[win];
          in1_d   = in1_a[win];
          in2_d   = in2_a[win];
          id_d    = IDW'(win);
          ptr_d   = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
          cnt_d   = CW'(ALU_LAT);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          data_d  = alu_out;
          err_d   = ~op_ok;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      f7_q    <= '0;
      f3_q    <= '0;
      opc_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      f7_q    <= f7_d;
      f3_q    <= f3_d;
      opc_q   <= opc_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      id_q    <= id_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign alu_funct7 = f7_q;
  assign alu_funct3 = f3_q;
  assign alu_opcode = opc_q;
  assign alu_in1    = in1_q;
  assign alu_in2    = in2_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != IDLE);

endmodule
